tile_op_sequencer: RTL and testbench

- Expands one decoded 32-bit tile instruction into per-cycle control strobes for the systolic datapath: row loads, swaps, shift wavefronts and accumulator write-back.
- Sits between the instruction-fetch FSM and the matrix datapath/scratchpad.
- Accepts instructions over a valid/ready handshake, reports busy, and pulses done on retire.

---
 rtl/tile_op_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_tile_op_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_op_sequencer.sv
// ---------------------------------------------------------------------------
// tile_op_sequencer
//
// Expands one decoded 32-bit tile instruction into per-cycle control strobes
// for the systolic datapath. Set groups run in the fixed order
// LOAD -> SWAP -> SHIFT -> ACC; an instruction with no group set runs a
// single NOP cycle.
//
// Optional feature macro: TILE_SEQ_PERF_EN
//   defined   : perf_busy_cycles (saturating) and perf_instr_count (wrapping)
//               are live counters, cleared only by fsm_rst.
//   undefined : both perf ports are tied to 0.
//
// Ports
//   clk               clock
//   fsm_rst           synchronous active-high reset
//   instr_valid/ready instruction handshake (ready only while IDLE)
//   instr             instruction word
//   abort             synchronous cancel of the running instruction
//   busy, done        activity flag / one-cycle retire pulse
//   phase_out         0 IDLE, 1 LOAD, 2 SWAP, 3 SHIFT, 4 ACC, 5 NOP
//   dp_addr           scratchpad address (read in LOAD, write in ACC)
//   dp_rd_en/wr_en    scratchpad strobes
//   load_left_en/top  latch read data into left/top buffer row load_row
//   swap_left/top     double-buffer swap pulses
//   shift_right/down  array shift enables
//   acc_rd_en/acc_row accumulator row read
//   perf_*            performance counters
// ---------------------------------------------------------------------------
module tile_op_sequencer #(
  parameter int MATRIX_SIZE   = 8,
  parameter int DP_ADDR_WIDTH = 10,
  parameter int INSTR_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           fsm_rst,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [INSTR_WIDTH-1:0]         instr,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     phase_out,
  output logic [DP_ADDR_WIDTH-1:0]       dp_addr,
  output logic                           dp_rd_en,
  output logic                           dp_wr_en,
  output logic                           load_left_en,
  output logic                           load_top_en,
  output logic [$clog2(MATRIX_SIZE)-1:0] load_row,
  output logic                           swap_left,
  output logic                           swap_top,
  output logic                           shift_right,
  output logic                           shift_down,
  output logic                           acc_rd_en,
  output logic [$clog2(MATRIX_SIZE)-1:0] acc_row,
  output logic [31:0]                    perf_busy_cycles,
  output logic [15:0]                    perf_instr_count
);

  localparam int ROW_W = $clog2(MATRIX_SIZE);
  // Counter must reach 2N-2 (last SHIFT cycle) and hold N.
  localparam int CNT_W = $clog2(2 * MATRIX_SIZE);
  localparam logic [CNT_W-1:0] N_K          = CNT_W'(MATRIX_SIZE);
  localparam logic [CNT_W-1:0] SHIFT_LAST_K = CNT_W'(2 * MATRIX_SIZE - 2);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_LOAD  = 3'd1,
    PH_SWAP  = 3'd2,
    PH_SHIFT = 3'd3,
    PH_ACC   = 3'd4,
    PH_NOP   = 3'd5
  } phase_t;

  phase_t                   phase, nxt_phase;
  logic [CNT_W-1:0]         k, nxt_k;

  // Latched instruction fields and their next values.
  logic                     f_ll, f_lt, f_sl, f_st, f_sr, f_sd, f_acc;
  logic                     n_ll, n_lt, n_sl, n_st, n_sr, n_sd, n_acc;
  logic [DP_ADDR_WIDTH-1:0] base, n_base;

  // Only the group bits and the base address are decoded; NOP (bit 20) is
  // implied by the absence of any group.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[24:DP_ADDR_WIDTH];

  function automatic phase_t first_group(input logic ld, input logic sw,
                                         input logic sh, input logic ac);
    if (ld)      return PH_LOAD;
    else if (sw) return PH_SWAP;
    else if (sh) return PH_SHIFT;
    else if (ac) return PH_ACC;
    else         return PH_NOP;
  endfunction

  function automatic phase_t next_group(input phase_t cur, input logic sw,
                                        input logic sh, input logic ac);
    case (cur)
      PH_LOAD:  return sw ? PH_SWAP : (sh ? PH_SHIFT : (ac ? PH_ACC : PH_IDLE));
      PH_SWAP:  return sh ? PH_SHIFT : (ac ? PH_ACC : PH_IDLE);
      PH_SHIFT: return ac ? PH_ACC : PH_IDLE;
      default:  return PH_IDLE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] last_k(input phase_t cur);
    case (cur)
      PH_LOAD, PH_ACC: return N_K;
      PH_SHIFT:        return SHIFT_LAST_K;
      default:         return '0;
    endcase
  endfunction

  always_comb begin
    nxt_phase = phase;
    nxt_k     = '0;
    n_ll      = f_ll;
    n_lt      = f_lt;
    n_sl      = f_sl;
    n_st      = f_st;
    n_sr      = f_sr;
    n_sd      = f_sd;
    n_acc     = f_acc;
    n_base    = base;
    if (phase == PH_IDLE) begin
      // abort wins over a simultaneous offer.
      if (instr_valid && !abort) begin
        n_ll      = instr[31];
        n_lt      = instr[30];
        n_sl      = instr[29];
        n_st      = instr[28];
        n_sr      = instr[27];
        n_sd      = instr[26];
        n_acc     = instr[25];
        n_base    = instr[DP_ADDR_WIDTH-1:0];
        nxt_phase = first_group(n_ll | n_lt, n_sl | n_st, n_sr | n_sd, n_acc);
      end
    end else if (abort) begin
      nxt_phase = PH_IDLE;
    end else if (k == last_k(phase)) begin
      nxt_phase = next_group(phase, f_sl | f_st, f_sr | f_sd, f_acc);
    end else begin
      nxt_k = k + CNT_W'(1);
    end
  end

  // Field latch: data only, meaningful whenever phase is not IDLE.
  always_ff @(posedge clk) begin
    f_ll  <= n_ll;
    f_lt  <= n_lt;
    f_sl  <= n_sl;
    f_st  <= n_st;
    f_sr  <= n_sr;
    f_sd  <= n_sd;
    f_acc <= n_acc;
    base  <= n_base;
  end

  // State plus registered strobes, derived from the state being entered so
  // every strobe lines up with its phase cycle.
  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      phase        <= PH_IDLE;
      k            <= '0;
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      dp_addr      <= '0;
      dp_rd_en     <= 1'b0;
      dp_wr_en     <= 1'b0;
      load_left_en <= 1'b0;
      load_top_en  <= 1'b0;
      load_row     <= '0;
      swap_left    <= 1'b0;
      swap_top     <= 1'b0;
      shift_right  <= 1'b0;
      shift_down   <= 1'b0;
      acc_rd_en    <= 1'b0;
      acc_row      <= '0;
    end else begin
      phase        <= nxt_phase;
      k            <= nxt_k;
      instr_ready  <= (nxt_phase == PH_IDLE);
      busy         <= (nxt_phase != PH_IDLE);
      done         <= (phase != PH_IDLE) && (nxt_phase == PH_IDLE) && !abort;
      dp_addr      <= '0;
      dp_rd_en     <= 1'b0;
      dp_wr_en     <= 1'b0;
      load_left_en <= 1'b0;
      load_top_en  <= 1'b0;
      load_row     <= '0;
      swap_left    <= 1'b0;
      swap_top     <= 1'b0;
      shift_right  <= 1'b0;
      shift_down   <= 1'b0;
      acc_rd_en    <= 1'b0;
      acc_row      <= '0;
      case (nxt_phase)
        PH_LOAD: begin
          if (nxt_k < N_K) begin
            dp_rd_en <= 1'b1;
            dp_addr  <= n_base + DP_ADDR_WIDTH'(nxt_k);
          end
          // Read data arrives one cycle after the address.
          if (nxt_k != '0) begin
            load_left_en <= n_ll;
            load_top_en  <= n_lt;
            load_row     <= ROW_W'(nxt_k - CNT_W'(1));
          end
        end
        PH_SWAP: begin
          swap_left <= n_sl;
          swap_top  <= n_st;
        end
        PH_SHIFT: begin
          shift_right <= n_sr;
          shift_down  <= n_sd;
        end
        PH_ACC: begin
          if (nxt_k < N_K) begin
            acc_rd_en <= 1'b1;
            acc_row   <= ROW_W'(nxt_k);
          end
          // Accumulator row is written back one cycle after it is read.
          if (nxt_k != '0) begin
            dp_wr_en <= 1'b1;
            dp_addr  <= n_base + DP_ADDR_WIDTH'(nxt_k - CNT_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign phase_out = phase;

`ifdef TILE_SEQ_PERF_EN
  logic [31:0] busy_cnt;
  logic [15:0] instr_cnt;

  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      busy_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy && (busy_cnt != '1)) busy_cnt <= busy_cnt + 32'd1;
      if (done) instr_cnt <= instr_cnt + 16'd1;
    end
  end

  assign perf_busy_cycles = busy_cnt;
  assign perf_instr_count = instr_cnt;
`else
  assign perf_busy_cycles = '0;
  assign perf_instr_count = '0;
`endif

endmodule

// File: tb/tb_tile_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tile_op_sequencer
//
// Each accepted instruction is expanded by a behavioural model into a queue
// of expected per-cycle output vectors (ending with the retire cycle); one
// step task compares the DUT against the head of that queue every cycle.
// Directed instructions additionally record a trace that is checked against
// hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_tile_op_sequencer;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          fsm_rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [31:0]   instr = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [2:0]    phase_out;
  logic [AW-1:0] dp_addr;
  logic          dp_rd_en, dp_wr_en, load_left_en, load_top_en;
  logic [RW-1:0] load_row, acc_row;
  logic          swap_left, swap_top, shift_right, shift_down, acc_rd_en;
  logic [31:0]   perf_busy_cycles;
  logic [15:0]   perf_instr_count;

  tile_op_sequencer #(.MATRIX_SIZE(N), .DP_ADDR_WIDTH(AW), .INSTR_WIDTH(32)) dut (
    .clk(clk), .fsm_rst(fsm_rst), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .abort(abort), .busy(busy),
    .done(done), .phase_out(phase_out), .dp_addr(dp_addr),
    .dp_rd_en(dp_rd_en), .dp_wr_en(dp_wr_en), .load_left_en(load_left_en),
    .load_top_en(load_top_en), .load_row(load_row), .swap_left(swap_left),
    .swap_top(swap_top), .shift_right(shift_right), .shift_down(shift_down),
    .acc_rd_en(acc_rd_en), .acc_row(acc_row),
    .perf_busy_cycles(perf_busy_cycles), .perf_instr_count(perf_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    phase;
    logic          busy, done, ready;
    logic [AW-1:0] addr;
    logic          rd, wr, lle, lte;
    logic [RW-1:0] lrow;
    logic          sl, st, sr, sd, accrd;
    logic [RW-1:0] arow;
  } out_t;

  out_t        q[$];
  out_t        cur;
  logic [31:0] exp_busy;
  logic [15:0] exp_instr;
  bit          model_on = 1'b0;
  bit          tracing = 1'b0;
  int          tc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0]   m_rd, m_wr, m_lle, m_lte, m_sl, m_st, m_sr, m_sd, m_acc;
  logic [31:0]   m_done, m_busy, m_ready;
  logic [AW-1:0] r_addr [32];
  logic [2:0]    r_phase [32];
  logic [RW-1:0] r_lrow [32];
  logic [RW-1:0] r_arow [32];
  logic [31:0]   r_pb [32];
  logic [15:0]   r_pi [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic out_t idle_o();
    out_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic out_t busy_o(input logic [2:0] ph);
    out_t e;
    e = '0;
    e.phase = ph;
    e.busy = 1'b1;
    return e;
  endfunction

  // Behavioural expansion of one instruction into its expected cycles.
  task automatic expand(input logic [31:0] ins);
    out_t e;
    logic [AW-1:0] b;
    logic ll, lt, sl, st, sr, sd, ac;
    b  = ins[AW-1:0];
    ll = ins[31]; lt = ins[30]; sl = ins[29]; st = ins[28];
    sr = ins[27]; sd = ins[26]; ac = ins[25];
    if (ll || lt) begin
      for (int j = 0; j <= N; j++) begin
        e = busy_o(3'd1);
        if (j < N) begin
          e.rd = 1'b1;
          e.addr = b + AW'(j);
        end
        if (j >= 1) begin
          e.lle = ll;
          e.lte = lt;
          e.lrow = RW'(j - 1);
        end
        q.push_back(e);
      end
    end
    if (sl || st) begin
      e = busy_o(3'd2);
      e.sl = sl;
      e.st = st;
      q.push_back(e);
    end
    if (sr || sd) begin
      for (int j = 0; j < 2 * N - 1; j++) begin
        e = busy_o(3'd3);
        e.sr = sr;
        e.sd = sd;
        q.push_back(e);
      end
    end
    if (ac) begin
      for (int j = 0; j <= N; j++) begin
        e = busy_o(3'd4);
        if (j < N) begin
          e.accrd = 1'b1;
          e.arow = RW'(j);
        end
        if (j >= 1) begin
          e.wr = 1'b1;
          e.addr = b + AW'(j - 1);
        end
        q.push_back(e);
      end
    end
    if (!(ll || lt || sl || st || sr || sd || ac)) q.push_back(busy_o(3'd5));
    e = idle_o();
    e.done = 1'b1;
    q.push_back(e);
  endtask

  // One clock cycle: check current outputs, drive inputs for the next edge,
  // advance the model, move to the next sampling point.
  task automatic step(input logic v, input logic [31:0] ins, input logic a, input logic r);
    out_t act;
    act.phase = phase_out; act.busy = busy; act.done = done; act.ready = instr_ready;
    act.addr = dp_addr; act.rd = dp_rd_en; act.wr = dp_wr_en;
    act.lle = load_left_en; act.lte = load_top_en; act.lrow = load_row;
    act.sl = swap_left; act.st = swap_top; act.sr = shift_right; act.sd = shift_down;
    act.accrd = acc_rd_en; act.arow = acc_row;
    if (model_on) begin
      check("outputs", 64'(act), 64'(cur));
      check("perf_busy_cycles", 64'(perf_busy_cycles), 64'(exp_busy));
      check("perf_instr_count", 64'(perf_instr_count), 64'(exp_instr));
    end
    if (tracing && tc < 32) begin
      m_rd[tc] = act.rd; m_wr[tc] = act.wr; m_lle[tc] = act.lle; m_lte[tc] = act.lte;
      m_sl[tc] = act.sl; m_st[tc] = act.st; m_sr[tc] = act.sr; m_sd[tc] = act.sd;
      m_acc[tc] = act.accrd; m_done[tc] = act.done; m_busy[tc] = act.busy;
      m_ready[tc] = act.ready;
      r_addr[tc] = act.addr; r_phase[tc] = act.phase; r_lrow[tc] = act.lrow;
      r_arow[tc] = act.arow; r_pb[tc] = perf_busy_cycles; r_pi[tc] = perf_instr_count;
      tc++;
    end
    instr_valid = v;
    instr = ins;
    abort = a;
    fsm_rst = r;
    if (r) begin
      q.delete();
      cur = idle_o();
      exp_busy = '0;
      exp_instr = '0;
      model_on = 1'b1;
    end else begin
`ifdef TILE_SEQ_PERF_EN
      if (cur.busy && exp_busy != '1) exp_busy = exp_busy + 32'd1;
      if (cur.done) exp_instr = exp_instr + 16'd1;
`endif
      if (cur.busy) begin
        if (a) begin
          q.delete();
          cur = idle_o();
        end else begin
          cur = q.pop_front();
        end
      end else if (v && !a) begin
        expand(ins);
        cur = q.pop_front();
      end else begin
        cur = idle_o();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_test();
    tracing = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    m_rd = '0; m_wr = '0; m_lle = '0; m_lte = '0; m_sl = '0; m_st = '0;
    m_sr = '0; m_sd = '0; m_acc = '0; m_done = '0; m_busy = '0; m_ready = '0;
    tc = 0;
    tracing = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int extra);
    begin_test();
    step(1'b1, ins, 1'b0, 1'b0);
    repeat (extra) step(1'b0, '0, 1'b0, 1'b0);
    tracing = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ri;
    logic rv, ra, rr;
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b1);
    check("reset_ready", 64'(instr_ready), 64'd1);
    check("reset_phase", 64'(phase_out), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 299) == 0);
      ra = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 2) != 0);
      ri = $urandom();
      case ($urandom_range(0, 3))
        0: ri = ri & 32'h00FF_FFFF;
        1: ri = ri & 32'h3DFF_FFFF;
        default: ;
      endcase
      step(rv, ri, ra, rr);
    end

    // LOAD both.
    run_instr(32'hC000_0003, 12);
    check("t1_rd_mask", 64'(m_rd), 64'h1FE);
    check("t1_addr_first", 64'(r_addr[1]), 64'h3);
    check("t1_addr_last", 64'(r_addr[8]), 64'hA);
    check("t1_lle_mask", 64'(m_lle), 64'h3FC);
    check("t1_lte_mask", 64'(m_lte), 64'h3FC);
    check("t1_row_first", 64'(r_lrow[2]), 64'd0);
    check("t1_row_last", 64'(r_lrow[9]), 64'd7);
    check("t1_done_mask", 64'(m_done), 64'h400);
    check("t1_phase", 64'(r_phase[1]), 64'd1);

    // LOAD with address wrap.
    run_instr(32'h8000_03FE, 12);
    check("t2_addr1", 64'(r_addr[1]), 64'h3FE);
    check("t2_addr2", 64'(r_addr[2]), 64'h3FF);
    check("t2_addr3", 64'(r_addr[3]), 64'h000);
    check("t2_addr8", 64'(r_addr[8]), 64'h005);
    check("t2_lte_mask", 64'(m_lte), 64'h0);
    check("t2_lle_mask", 64'(m_lle), 64'h3FC);

    // Combined swap + shift.
    run_instr(32'h3C00_0000, 19);
    check("t3_sl_mask", 64'(m_sl), 64'h2);
    check("t3_st_mask", 64'(m_st), 64'h2);
    check("t3_sr_mask", 64'(m_sr), 64'h1FFFC);
    check("t3_sd_mask", 64'(m_sd), 64'h1FFFC);
    check("t3_done_mask", 64'(m_done), 64'h20000);

    // ACC write-back.
    run_instr(32'h0200_0010, 12);
    check("t4_acc_mask", 64'(m_acc), 64'h1FE);
    check("t4_row_first", 64'(r_arow[1]), 64'd0);
    check("t4_row_last", 64'(r_arow[8]), 64'd7);
    check("t4_wr_mask", 64'(m_wr), 64'h3FC);
    check("t4_addr_first", 64'(r_addr[2]), 64'h10);
    check("t4_addr_last", 64'(r_addr[9]), 64'h17);
    check("t4_done_mask", 64'(m_done), 64'h400);
    check("t4_rd_mask", 64'(m_rd), 64'h0);

    // Abort during LOAD.
    begin_test();
    step(1'b1, 32'h8000_0001, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    tracing = 1'b0;
    check("t5_phase_after", 64'(r_phase[5]), 64'd0);
    check("t5_rd_mask", 64'(m_rd), 64'h1E);
    check("t5_lle_mask", 64'(m_lle), 64'h1C);
    check("t5_done_mask", 64'(m_done), 64'h0);
    check("t5_busy_mask", 64'(m_busy), 64'h1E);
    check("t5_ready_mask", 64'(m_ready), 64'h1E1);

    // Reset during LOAD.
    begin_test();
    step(1'b1, 32'h8000_0001, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    tracing = 1'b0;
    check("t6_phase_after", 64'(r_phase[5]), 64'd0);
    check("t6_rd_mask", 64'(m_rd), 64'h1E);
    check("t6_lle_mask", 64'(m_lle), 64'h1C);
    check("t6_done_mask", 64'(m_done), 64'h0);
    check("t6_ready_mask", 64'(m_ready), 64'h1E1);
    check("t6_perf_busy_cleared", 64'(r_pb[5]), 64'd0);
    check("t6_perf_instr_cleared", 64'(r_pi[5]), 64'd0);
`ifdef TILE_SEQ_PERF_EN
    check("t6_perf_busy_before", 64'(r_pb[4]), 64'd3);
`endif

    // Back-to-back NOPs with instr_valid held.
    begin_test();
    step(1'b1, 32'h0010_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    tracing = 1'b0;
    check("t7_phase1", 64'(r_phase[1]), 64'd5);
    check("t7_phase3", 64'(r_phase[3]), 64'd5);
    check("t7_done_mask", 64'(m_done), 64'h14);
    check("t7_busy_mask", 64'(m_busy), 64'h0A);
`ifdef TILE_SEQ_PERF_EN
    check("t7_perf_instr", 64'(r_pi[5]), 64'd2);
    check("t7_perf_busy", 64'(r_pb[5]), 64'd2);
`else
    check("t7_perf_instr", 64'(r_pi[5]), 64'd0);
    check("t7_perf_busy", 64'(r_pb[5]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
